// File: rtl/rasterizer_mem_pkg.sv
// Shared types and SDRAM bus widths for the rasterizer memory arbiter.
package rasterizer_mem_pkg;
  localparam int SDRAM_ADDR_W = 26;
  localparam int SDRAM_DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} arb_state_t;
  typedef enum logic {GNT_R, GNT_W} grant_t;
endpackage

// File: rtl/rasterizer_rr_arbiter2.sv
// Two-way round-robin picker: on contention the port that did not win last time wins.
module rasterizer_rr_arbiter2
  import rasterizer_mem_pkg::*;
(
  input  logic [1:0] req_i,         // [0] = port R, [1] = port W
  input  grant_t     last_grant_i,
  output grant_t     grant_o,
  output logic       valid_o
);
  always_comb begin
    grant_o = GNT_R;
    if (req_i == 2'b11) grant_o = (last_grant_i == GNT_R) ? GNT_W : GNT_R;
    else if (req_i[1])  grant_o = GNT_W;
  end

  assign valid_o = |req_i;
endmodule

// File: rtl/rasterizer_mem_arbiter.sv
// Shares one SDRAM Avalon-MM master between the depth-fetch read port and the writeback port.
module rasterizer_mem_arbiter
  import rasterizer_mem_pkg::*;
#(
  parameter int ADDR_W          = SDRAM_ADDR_W,
  parameter int DATA_W          = SDRAM_DATA_W,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_address,
  input  logic                rd_read,
  output logic                rd_waitrequest,
  output logic [DATA_W-1:0]   rd_readdata,
  output logic                rd_readdatavalid,
  input  logic [ADDR_W-1:0]   wr_address,
  input  logic                wr_write,
  input  logic [DATA_W-1:0]   wr_writedata,
  input  logic [DATA_W/8-1:0] wr_byteenable,
  output logic                wr_waitrequest,
  output logic [ADDR_W-1:0]   master_address,
  output logic                master_read,
  output logic                master_write,
  output logic [DATA_W-1:0]   master_writedata,
  output logic [DATA_W/8-1:0] master_byteenable,
  input  logic                master_waitrequest,
  input  logic [DATA_W-1:0]   master_readdata,
  input  logic                master_readdatavalid,
  output logic [CNT_W-1:0]    outstanding,
  output logic                err_underflow
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  arb_state_t          state_q, state_d;
  grant_t              last_grant_q, last_grant_d, grant;
  logic                arb_valid;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic                read_q, read_d, write_q, write_d;
  logic                rd_accept, wr_accept;

  rasterizer_rr_arbiter2 u_rr (
    .req_i        ({wr_write, rd_read && (cnt_q < MAX_CNT)}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .valid_o      (arb_valid)
  );

  assign rd_accept = (state_q == S_READ)  && !master_waitrequest;
  assign wr_accept = (state_q == S_WRITE) && !master_waitrequest;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    read_d       = read_q;
    write_d      = write_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          last_grant_d = grant;
          if (grant == GNT_R) begin
            addr_d  = rd_address;
            be_d    = '1;
            read_d  = 1'b1;
            state_d = S_READ;
          end else begin
            addr_d  = wr_address;
            wdata_d = wr_writedata;
            be_d    = wr_byteenable;
            write_d = 1'b1;
            state_d = S_WRITE;
          end
        end
      end
      S_READ, S_WRITE: begin
        if (!master_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A return with nothing in flight is flagged but never wraps the counter.
    case ({rd_accept, master_readdatavalid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (master_readdatavalid && cnt_q == '0) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_W;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      read_q       <= read_d;
      write_q      <= write_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign rd_waitrequest    = !rd_accept;
  assign wr_waitrequest    = !wr_accept;
  assign rd_readdata       = master_readdata;
  assign rd_readdatavalid  = master_readdatavalid;
  assign master_address    = addr_q;
  assign master_read       = read_q;
  assign master_write      = write_q;
  assign master_writedata  = wdata_q;
  assign master_byteenable = be_q;
  assign outstanding       = cnt_q;
  assign err_underflow     = err_q;
endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Directed bench for rasterizer_mem_arbiter: reset, single read, round robin, read limit, write, underflow.
module tb_rasterizer_mem_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_address, wr_address, master_address;
  logic          rd_read, rd_waitrequest, rd_readdatavalid;
  logic [DW-1:0] rd_readdata, wr_writedata, master_writedata, master_readdata;
  logic          wr_write, wr_waitrequest;
  logic [BW-1:0] wr_byteenable, master_byteenable;
  logic          master_read, master_write, master_waitrequest, master_readdatavalid;
  logic [CW-1:0] outstanding;
  logic          err_underflow;

  int vec = 0;
  int miss = 0;

  always #5 clock = ~clock;

  rasterizer_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .rd_address(rd_address), .rd_read(rd_read), .rd_waitrequest(rd_waitrequest),
    .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
    .wr_address(wr_address), .wr_write(wr_write), .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable), .wr_waitrequest(wr_waitrequest),
    .master_address(master_address), .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_byteenable(master_byteenable),
    .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; rd_read = 1'b0; wr_write = 1'b0;
    master_waitrequest = 1'b0; master_readdatavalid = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_read = 1'b1; wr_write = 1'b1;
    rd_address = 26'h40; wr_address = 26'h80;
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      vec++; if (master_read !== 1'b0 || master_write !== 1'b0) begin
        miss++; $display("FAIL reset_cmd[%0d]: read=%b write=%b want 0 0", i, master_read, master_write); end
      vec++; if (rd_waitrequest !== 1'b1 || wr_waitrequest !== 1'b1) begin
        miss++; $display("FAIL reset_wait[%0d]: rd=%b wr=%b want 1 1", i, rd_waitrequest, wr_waitrequest); end
      vec++; if (outstanding !== 4'd0 || err_underflow !== 1'b0) begin
        miss++; $display("FAIL reset_cnt[%0d]: cnt=%0d err=%b want 0 0", i, outstanding, err_underflow); end
    end
    rd_read = 1'b0; wr_write = 1'b0; reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    rd_address = 26'h100; rd_read = 1'b1; master_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) master_waitrequest = 1'b0;
      settle();
      vec++; if (master_read !== 1'b1 || master_address !== 26'h100) begin
        miss++; $display("FAIL rd_hold[%0d]: read=%b addr=%h want 1 100", i, master_read, master_address); end
      vec++; if (rd_waitrequest !== (i != 2) || wr_waitrequest !== 1'b1) begin
        miss++; $display("FAIL rd_wait[%0d]: rd=%b wr=%b want %b 1", i, rd_waitrequest, wr_waitrequest, i != 2); end
    end
    cyc(); rd_read = 1'b0; settle();
    vec++; if (master_read !== 1'b0 || rd_waitrequest !== 1'b1 || outstanding !== 4'd1) begin
      miss++; $display("FAIL rd_done: read=%b wait=%b cnt=%0d want 0 1 1", master_read, rd_waitrequest, outstanding); end
    master_readdata = 32'hDEADBEEF; master_readdatavalid = 1'b1; #1;
    vec++; if (rd_readdatavalid !== 1'b1 || rd_readdata !== 32'hDEADBEEF) begin
      miss++; $display("FAIL rd_data: valid=%b data=%h want 1 deadbeef", rd_readdatavalid, rd_readdata); end
    cyc(); master_readdatavalid = 1'b0; settle();
    vec++; if (outstanding !== 4'd0 || err_underflow !== 1'b0) begin
      miss++; $display("FAIL rd_drain: cnt=%0d err=%b want 0 0", outstanding, err_underflow); end
  endtask

  task automatic test_round_robin();
    int k;
    logic exp_r;
    do_reset();
    k = 0;
    rd_address = 26'h10; wr_address = 26'h20; rd_read = 1'b1; wr_write = 1'b1;
    for (int c = 0; c < 30 && k < 6; c++) begin
      cyc(); settle();
      if (!master_waitrequest && (master_read || master_write)) begin
        exp_r = (k % 2 == 0);
        vec++; if (master_read !== exp_r || master_write !== !exp_r) begin
          miss++; $display("FAIL rr_order[%0d]: read=%b write=%b want %b %b", k, master_read, master_write, exp_r, !exp_r); end
        vec++; if (rd_waitrequest !== !exp_r || wr_waitrequest !== exp_r) begin
          miss++; $display("FAIL rr_wait[%0d]: rd=%b wr=%b want %b %b", k, rd_waitrequest, wr_waitrequest, !exp_r, exp_r); end
        vec++; if (master_address !== (exp_r ? 26'h10 : 26'h20)) begin
          miss++; $display("FAIL rr_addr[%0d]: got %h want %h", k, master_address, exp_r ? 26'h10 : 26'h20); end
        k++;
      end
    end
    vec++; if (k != 6) begin
      miss++; $display("FAIL rr_timeout: accepts=%0d want 6", k); end
    cyc(); rd_read = 1'b0; wr_write = 1'b0; settle();
    vec++; if (outstanding !== 4'd3) begin
      miss++; $display("FAIL rr_cnt: got %0d want 3", outstanding); end
  endtask

  task automatic test_max_outstanding();
    int k;
    int exp_next;
    logic exp_r;
    do_reset();
    k = 0; exp_next = -1;
    rd_address = 26'h30; wr_address = 26'h50; rd_read = 1'b1; wr_write = 1'b1;
    for (int c = 0; c < 100 && k < 26; c++) begin
      cyc(); master_readdatavalid = 1'b0; settle();
      if (exp_next >= 0) begin
        vec++; if (outstanding !== 4'(exp_next)) begin
          miss++; $display("FAIL max_cnt_after[%0d]: got %0d want %0d", k, outstanding, exp_next); end
        exp_next = -1;
      end
      if (!master_waitrequest && (master_read || master_write)) begin
        exp_r = (k < 16) ? (k % 2 == 0) : (k == 20 || k == 22);
        vec++; if (master_read !== exp_r || rd_waitrequest !== !exp_r) begin
          miss++; $display("FAIL max_order[%0d]: read=%b rdwait=%b want %b %b", k, master_read, rd_waitrequest, exp_r, !exp_r); end
        // Return one read beside the 20th write accept and again beside the next read accept.
        if (k == 19 || k == 20) begin
          master_readdatavalid = 1'b1; exp_next = 7;
        end
        k++;
      end
    end
    vec++; if (k != 26) begin
      miss++; $display("FAIL max_timeout: accepts=%0d want 26", k); end
    vec++; if (outstanding !== 4'd8) begin
      miss++; $display("FAIL max_final: got %0d want 8", outstanding); end
    rd_read = 1'b0; wr_write = 1'b0;
  endtask

  task automatic test_write();
    do_reset();
    wr_address = 26'h200; wr_writedata = 32'h12345678; wr_byteenable = 4'b0011;
    wr_write = 1'b1; master_waitrequest = 1'b1;
    cyc(); settle();
    vec++; if (master_write !== 1'b1 || wr_waitrequest !== 1'b1) begin
      miss++; $display("FAIL wr_stall: write=%b wait=%b want 1 1", master_write, wr_waitrequest); end
    cyc(); master_waitrequest = 1'b0; settle();
    vec++; if (master_write !== 1'b1 || master_read !== 1'b0 || master_address !== 26'h200) begin
      miss++; $display("FAIL wr_cmd: write=%b read=%b addr=%h want 1 0 200", master_write, master_read, master_address); end
    vec++; if (master_writedata !== 32'h12345678 || master_byteenable !== 4'b0011) begin
      miss++; $display("FAIL wr_data: data=%h be=%b want 12345678 0011", master_writedata, master_byteenable); end
    vec++; if (wr_waitrequest !== 1'b0 || rd_waitrequest !== 1'b1) begin
      miss++; $display("FAIL wr_accept: wr=%b rd=%b want 0 1", wr_waitrequest, rd_waitrequest); end
    cyc(); wr_write = 1'b0; settle();
    vec++; if (master_write !== 1'b0 || wr_waitrequest !== 1'b1 || outstanding !== 4'd0) begin
      miss++; $display("FAIL wr_done: write=%b wait=%b cnt=%0d want 0 1 0", master_write, wr_waitrequest, outstanding); end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    master_readdata = 32'hCAFE0001; master_readdatavalid = 1'b1; settle();
    vec++; if (rd_readdatavalid !== 1'b1 || rd_readdata !== 32'hCAFE0001) begin
      miss++; $display("FAIL uf_fwd: valid=%b data=%h want 1 cafe0001", rd_readdatavalid, rd_readdata); end
    cyc(); master_readdatavalid = 1'b0; settle();
    vec++; if (err_underflow !== 1'b1 || outstanding !== 4'd0) begin
      miss++; $display("FAIL uf_flag: err=%b cnt=%0d want 1 0", err_underflow, outstanding); end
    cyc(); cyc(); settle();
    vec++; if (err_underflow !== 1'b1) begin
      miss++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
    rd_address = 26'h300; rd_read = 1'b1; master_waitrequest = 1'b1;
    cyc(); settle();
    vec++; if (master_read !== 1'b1 || master_address !== 26'h300) begin
      miss++; $display("FAIL rst_pre: read=%b addr=%h want 1 300", master_read, master_address); end
    cyc(); reset = 1'b1; settle();
    cyc(); settle();
    vec++; if (master_read !== 1'b0 || err_underflow !== 1'b0 || outstanding !== 4'd0) begin
      miss++; $display("FAIL rst_mid: read=%b err=%b cnt=%0d want 0 0 0", master_read, err_underflow, outstanding); end
    reset = 1'b0; rd_read = 1'b0; master_waitrequest = 1'b0; master_readdatavalid = 1'b1;
    cyc(); master_readdatavalid = 1'b0; settle();
    vec++; if (err_underflow !== 1'b1) begin
      miss++; $display("FAIL rst_late: err=%b want 1", err_underflow); end
  endtask

  initial begin
    reset = 1'b1; rd_read = 1'b0; wr_write = 1'b0;
    rd_address = '0; wr_address = '0; wr_writedata = '0; wr_byteenable = '0;
    master_waitrequest = 1'b0; master_readdata = '0; master_readdatavalid = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_max_outstanding();
    test_write();
    test_underflow_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
